// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the register-bank write arbiter:
//   REG_IDX_W  - width of a register index (32 architectural registers)
//   req_id_e   - requester identity (REQ_ALU = req0, REQ_MEM = req1)
//   wb_entry_t - one queued write {reg_idx, data} at the default 32-bit width
// -----------------------------------------------------------------------------
package regbank_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int DEFAULT_SIZE = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // Field is called reg_idx because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_IDX_W-1:0]    reg_idx;
    logic [DEFAULT_SIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// DEPTH-entry FIFO holding pending writeback entries {reg_idx, data}.
// Ports:
//   clock, reset_n       - clock, asynchronous active-low reset
//   push, push_entry     - enqueue (caller guarantees !full)
//   pop                  - dequeue head (caller guarantees !empty)
//   head_entry           - current head entry (valid when !empty)
//   full, empty, count   - occupancy status, all registered-state derived
// Entry layout: {reg_idx[REG_IDX_W-1:0], data[SIZE-1:0]}.
// -----------------------------------------------------------------------------
module wb_queue
  import regbank_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [REG_IDX_W+SIZE-1:0]    push_entry,
  input  logic                         pop,
  output logic [REG_IDX_W+SIZE-1:0]    head_entry,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int WIDTH = REG_IDX_W + SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer increments wrap naturally.
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: rtl/regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter
// Shares the register bank's single write port between req0 (ALU results) and
// req1 (load/memory results). Each requester feeds a DEPTH-entry wb_queue; a
// round-robin arbiter drains one entry per cycle into registered outputs that
// drive the bank's RegWrite/WriteReg/WriteData directly.
//
// Handshake: an entry is accepted at a rising edge when reqN_valid && reqN_ready.
// reqN_ready is simply !full of that queue; it never depends on valid or on a
// pop happening in the same cycle.
//
// Ports:
//   clock, reset_n               - clock, asynchronous active-low reset
//   req0_valid/ready/reg/data    - ALU writeback requester
//   req1_valid/ready/reg/data    - memory writeback requester
//   RegWrite, WriteReg, WriteData- registered write port to the bank
//   idle                         - both queues empty and no strobe pending
//
// Build option ZERO_REG_FILTER_EN: when defined, a granted entry targeting
// register 0 is popped and counts for arbitration, but no strobe is issued
// and WriteReg/WriteData hold.
// -----------------------------------------------------------------------------
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [REG_IDX_W-1:0] req0_reg,
  input  logic [SIZE-1:0]      req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [REG_IDX_W-1:0] req1_reg,
  input  logic [SIZE-1:0]      req1_data,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic [SIZE-1:0]      WriteData,
  output logic                 idle
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic                        push0, push1, pop0, pop1;
  logic                        full0, full1, empty0, empty1;
  logic [REG_IDX_W+SIZE-1:0]   head0, head1;
  logic [CNT_W-1:0]            count0, count1;

  assign req0_ready = !full0;
  assign req1_ready = !full1;
  assign push0      = req0_valid && req0_ready;
  assign push1      = req1_valid && req1_ready;

  wb_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) u_q0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push0),
    .push_entry ({req0_reg, req0_data}),
    .pop        (pop0),
    .head_entry (head0),
    .full       (full0),
    .empty      (empty0),
    .count      (count0)
  );

  wb_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) u_q1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push1),
    .push_entry ({req1_reg, req1_data}),
    .pop        (pop1),
    .head_entry (head1),
    .full       (full1),
    .empty      (empty1),
    .count      (count1)
  );

  // Round-robin: with both queues nonempty, the requester not granted last wins.
  req_id_e last_q, last_d;
  logic    grant_any;
  req_id_e grant_id;

  assign pop0      = !empty0 && (empty1 || (last_q == REQ_MEM));
  assign pop1      = !empty1 && (empty0 || (last_q == REQ_ALU));
  assign grant_any = pop0 || pop1;
  assign grant_id  = pop1 ? REQ_MEM : REQ_ALU;

  logic [REG_IDX_W+SIZE-1:0] grant_entry;
  logic [REG_IDX_W-1:0]      grant_reg;
  logic [SIZE-1:0]           grant_data;
  logic                      write_en;

  assign grant_entry = pop1 ? head1 : head0;
  assign grant_reg   = grant_entry[SIZE +: REG_IDX_W];
  assign grant_data  = grant_entry[SIZE-1:0];

`ifdef ZERO_REG_FILTER_EN
  assign write_en = (grant_reg != '0);
`else
  assign write_en = 1'b1;
`endif

  logic                 regwrite_q, regwrite_d;
  logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
  logic [SIZE-1:0]      write_data_q, write_data_d;

  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    last_d       = last_q;
    if (grant_any) begin
      last_d     = grant_id;
      regwrite_d = write_en;
      if (write_en) begin
        write_reg_d  = grant_reg;
        write_data_d = grant_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      last_q       <= REQ_MEM;  // req0 wins the first contested grant
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      last_q       <= last_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign idle      = (count0 == '0) && (count1 == '0) && !regwrite_q;

endmodule
